// File: rtl/room_pkg.sv
// Shared types and default widths for the room energy controller.
//   ctrl_state_t      : sequencer states (idle, accumulate, snapshot, clear)
//   DEFAULT_CLK_W     : accumulator width; one carry-out is one energy unit
//   DEFAULT_PEOPLE_W  : occupancy counter width
//   DEFAULT_ENERGY_W  : energy counter width
package room_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SNAP  = 2'd2,
        CLEAR = 2'd3
    } ctrl_state_t;

    localparam int DEFAULT_CLK_W    = 6;
    localparam int DEFAULT_PEOPLE_W = 5;
    localparam int DEFAULT_ENERGY_W = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, chained to build the accumulator adder.
//   a, b  : operand bits
//   cin   : carry in
//   sum   : sum bit
//   cout  : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : person entered (one-cycle pulse)
//   dec        : person left (one-cycle pulse)
//   count      : current occupancy, clamps at 0 and at all-ones
// Simultaneous inc and dec cancel out.
module occupancy_counter
    import room_pkg::*;
#(
    parameter int PEOPLE_W = DEFAULT_PEOPLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic [PEOPLE_W-1:0] count
);

    localparam logic [PEOPLE_W-1:0] COUNT_MAX = '1;

    logic [PEOPLE_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && count_q != COUNT_MAX) begin
            count_d = count_q + PEOPLE_W'(1);
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - PEOPLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/room_energy_ctrl.sv
// Smart-room energy sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enter_pulse  : person entered      exit_pulse : person left
//   clr_req      : level, zero accumulator/energy
//   rd_req       : level, request an energy snapshot
//   rd_ack       : host took the snapshot (only honoured while snapshotting)
//   people_count : occupancy           energy     : live energy count
//   rd_data      : snapshot value      rd_valid   : snapshot available
//   clr_done     : pulse in the clear cycle
//   over_limit   : energy >= ENERGY_LIMIT
//   tick_lost    : sticky, a tick hit a full pending counter
// A prescaler produces one tick every TICK_DIV cycles. Ticks queue in a small
// pending counter; the sequencer drains one per ACCUM cycle, adding the
// occupancy into the accumulator and counting accumulator carry-outs.
module room_energy_ctrl
    import room_pkg::*;
#(
    parameter int CLK_W        = DEFAULT_CLK_W,
    parameter int PEOPLE_W     = DEFAULT_PEOPLE_W,
    parameter int ENERGY_W     = DEFAULT_ENERGY_W,
    parameter int TICK_DIV     = 16,
    parameter int ENERGY_LIMIT = 200,
    parameter int PEND_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enter_pulse,
    input  logic                exit_pulse,
    input  logic                clr_req,
    input  logic                rd_req,
    input  logic                rd_ack,
    output logic [PEOPLE_W-1:0] people_count,
    output logic [ENERGY_W-1:0] energy,
    output logic [ENERGY_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                clr_done,
    output logic                over_limit,
    output logic                tick_lost
);

    localparam int                  PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [ENERGY_W-1:0] ENERGY_MAX = '1;
    localparam logic [ENERGY_W-1:0] ENERGY_THR = ENERGY_W'(ENERGY_LIMIT);
    localparam logic [PEND_W-1:0]   PEND_MAX   = '1;

    ctrl_state_t         state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [CLK_W-1:0]    acc_q, acc_d;
    logic [ENERGY_W-1:0] energy_q, energy_d;
    logic [ENERGY_W-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                tick_lost_q, tick_lost_d;

    logic                tick;
    logic                pend_dec;
    logic [PEOPLE_W-1:0] people_w;
    logic [CLK_W-1:0]    people_ext;
    logic [CLK_W-1:0]    acc_sum;
    logic [CLK_W:0]      carry;

    occupancy_counter #(
        .PEOPLE_W (PEOPLE_W)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enter_pulse),
        .dec   (exit_pulse),
        .count (people_w)
    );

    // Ripple adder: acc + zero-extended occupancy; carry[CLK_W] is one energy unit.
    assign people_ext = CLK_W'(people_w);
    assign carry[0]   = 1'b0;

    generate
        for (genvar gi = 0; gi < CLK_W; gi++) begin : g_acc_add
            full_adder u_fa (
                .a    (acc_q[gi]),
                .b    (people_ext[gi]),
                .cin  (carry[gi]),
                .sum  (acc_sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        tick        = (presc_q == PRESC_LAST);
        presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
        state_d     = state_q;
        acc_d       = acc_q;
        energy_d    = energy_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        tick_lost_d = tick_lost_q;
        pend_dec    = 1'b0;
        pend_d      = pend_q;

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (pend_q != '0) begin
                    state_d = ACCUM;
                end else if (rd_req) begin
                    // Capture the snapshot on the way in so it is valid on SNAP entry.
                    state_d    = SNAP;
                    rd_data_d  = energy_q;
                    rd_valid_d = 1'b1;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                if (carry[CLK_W] && energy_q != ENERGY_MAX) begin
                    energy_d = energy_q + ENERGY_W'(1);
                end
                pend_dec = 1'b1;
                state_d  = IDLE;
            end
            SNAP: begin
                if (rd_ack) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            CLEAR: begin
                acc_d       = '0;
                energy_d    = '0;
                tick_lost_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pending ticks: CLEAR wins (drops any coincident tick); tick+drain cancel.
        if (state_q == CLEAR) begin
            pend_d = '0;
        end else if (tick && !pend_dec) begin
            if (pend_q == PEND_MAX) begin
                tick_lost_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!tick && pend_dec) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            pend_q      <= '0;
            acc_q       <= '0;
            energy_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            tick_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            pend_q      <= pend_d;
            acc_q       <= acc_d;
            energy_q    <= energy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            tick_lost_q <= tick_lost_d;
        end
    end

    assign people_count = people_w;
    assign energy       = energy_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign clr_done     = (state_q == CLEAR);
    assign over_limit   = (energy_q >= ENERGY_THR);
    assign tick_lost    = tick_lost_q;

endmodule

// File: tb/tb_room_energy_ctrl.sv
// Bench for room_energy_ctrl: a cycle-level behavioural model compared against
// the DUT on every falling edge, plus directed scenarios with literal checks.
module tb_room_energy_ctrl;

    localparam int CLK_W        = 6;
    localparam int PEOPLE_W     = 5;
    localparam int ENERGY_W     = 8;
    localparam int TICK_DIV     = 16;
    localparam int ENERGY_LIMIT = 200;
    localparam int PEND_W       = 3;
    localparam int ACC_MOD      = 1 << CLK_W;
    localparam int PEOPLE_MAX   = (1 << PEOPLE_W) - 1;
    localparam int ENERGY_MAX   = (1 << ENERGY_W) - 1;
    localparam int PEND_MAX     = (1 << PEND_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enter_pulse = 1'b0;
    logic                exit_pulse = 1'b0;
    logic                clr_req = 1'b0;
    logic                rd_req = 1'b0;
    logic                rd_ack = 1'b0;
    logic [PEOPLE_W-1:0] people_count;
    logic [ENERGY_W-1:0] energy;
    logic [ENERGY_W-1:0] rd_data;
    logic                rd_valid;
    logic                clr_done;
    logic                over_limit;
    logic                tick_lost;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state
    int    m_people = 0;
    int    m_presc = 0;
    int    m_pend = 0;
    int    m_acc = 0;
    int    m_energy = 0;
    int    m_rd_data = 0;
    int    m_rd_valid = 0;
    int    m_lost = 0;
    string m_mode = "idle";

    room_energy_ctrl #(
        .CLK_W        (CLK_W),
        .PEOPLE_W     (PEOPLE_W),
        .ENERGY_W     (ENERGY_W),
        .TICK_DIV     (TICK_DIV),
        .ENERGY_LIMIT (ENERGY_LIMIT),
        .PEND_W       (PEND_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enter_pulse  (enter_pulse),
        .exit_pulse   (exit_pulse),
        .clr_req      (clr_req),
        .rd_req       (rd_req),
        .rd_ack       (rd_ack),
        .people_count (people_count),
        .energy       (energy),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .clr_done     (clr_done),
        .over_limit   (over_limit),
        .tick_lost    (tick_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_people   = 0;
        m_presc    = 0;
        m_pend     = 0;
        m_acc      = 0;
        m_energy   = 0;
        m_rd_data  = 0;
        m_rd_valid = 0;
        m_lost     = 0;
        m_mode     = "idle";
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic m_step();
        int    n_people   = m_people;
        int    n_pend     = m_pend;
        int    n_acc      = m_acc;
        int    n_energy   = m_energy;
        int    n_rd_data  = m_rd_data;
        int    n_rd_valid = m_rd_valid;
        int    n_lost     = m_lost;
        string n_mode     = m_mode;
        int    tick       = (m_presc == TICK_DIV - 1) ? 1 : 0;
        int    drained    = 0;
        int    sum;

        if (enter_pulse && !exit_pulse && m_people < PEOPLE_MAX) n_people = m_people + 1;
        if (exit_pulse && !enter_pulse && m_people > 0)          n_people = m_people - 1;

        if (m_mode == "idle") begin
            if (clr_req)          n_mode = "clear";
            else if (m_pend != 0) n_mode = "accum";
            else if (rd_req) begin
                n_mode     = "snap";
                n_rd_data  = m_energy;
                n_rd_valid = 1;
            end
        end else if (m_mode == "accum") begin
            sum   = m_acc + m_people;
            n_acc = sum % ACC_MOD;
            if (sum >= ACC_MOD && m_energy < ENERGY_MAX) n_energy = m_energy + 1;
            drained = 1;
            n_mode  = "idle";
        end else if (m_mode == "snap") begin
            if (rd_ack) begin
                n_rd_valid = 0;
                n_mode     = "idle";
            end
        end else begin
            n_acc    = 0;
            n_energy = 0;
            n_lost   = 0;
            n_mode   = "idle";
        end

        if (m_mode == "clear") begin
            n_pend = 0;
        end else begin
            n_pend = m_pend + tick - drained;
            if (n_pend > PEND_MAX) begin
                n_pend = PEND_MAX;
                n_lost = 1;
            end
        end

        m_people   = n_people;
        m_presc    = (m_presc + 1) % TICK_DIV;
        m_pend     = n_pend;
        m_acc      = n_acc;
        m_energy   = n_energy;
        m_rd_data  = n_rd_data;
        m_rd_valid = n_rd_valid;
        m_lost     = n_lost;
        m_mode     = n_mode;
    endtask

    // Per-cycle compare on the falling edge, then model advance.
    always @(negedge clk) begin
        if (!rst_n) m_reset();
        chk("people_count", int'(people_count), m_people);
        chk("energy",       int'(energy),       m_energy);
        chk("rd_valid",     int'(rd_valid),     m_rd_valid);
        chk("rd_data",      int'(rd_data),      m_rd_data);
        chk("clr_done",     int'(clr_done),     (m_mode == "clear") ? 1 : 0);
        chk("over_limit",   int'(over_limit),   (m_energy >= ENERGY_LIMIT) ? 1 : 0);
        chk("tick_lost",    int'(tick_lost),    m_lost);
        if (rst_n) m_step();
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_presc(input int v);
        int k = 0;
        while (m_presc != v && k < 2 * TICK_DIV) begin
            cyc(1);
            k++;
        end
        if (m_presc != v) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_presc: timed out at phase %0d, wanted %0d", m_presc, v);
        end
    endtask

    // Let exactly one tick happen and be accumulated.
    task automatic run_ticks(input int n);
        repeat (n) begin
            cyc(1);
            wait_presc(0);
            cyc(3);
        end
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        cyc(1);
        clr_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset state
        cyc(3);
        chk("rst_people", int'(people_count), 0);
        chk("rst_energy", int'(energy), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        rst_n = 1'b1;

        // 1: three entries, one tick
        repeat (3) begin
            enter_pulse = 1'b1; cyc(1);
            enter_pulse = 1'b0; cyc(1);
        end
        run_ticks(1);
        chk("s1_people", int'(people_count), 3);
        chk("s1_model_acc", m_acc, 3);
        chk("s1_energy", int'(energy), 0);
        $display("txn 1: people=%0d energy=%0d", people_count, energy);

        // 2: occupancy 20, four ticks from a cleared accumulator
        pulse_clr(); cyc(2);
        enter_pulse = 1'b1; cyc(17); enter_pulse = 1'b0;
        run_ticks(1);
        pulse_clr(); cyc(2);
        chk("s2_people", int'(people_count), 20);
        chk("s2_energy_clr", int'(energy), 0);
        chk("s2_model_acc0", m_acc, 0);
        run_ticks(1); chk("s2_model_acc1", m_acc, 20);
        run_ticks(1); chk("s2_model_acc2", m_acc, 40);
        run_ticks(1); chk("s2_model_acc3", m_acc, 60);
        chk("s2_energy3", int'(energy), 0);
        run_ticks(1); chk("s2_model_acc4", m_acc, 16);
        chk("s2_energy4", int'(energy), 1);
        $display("txn 2: people=%0d energy=%0d", people_count, energy);

        // 3: occupancy boundaries
        exit_pulse = 1'b1; cyc(25); exit_pulse = 1'b0;
        chk("s3_exit_floor", int'(people_count), 0);
        enter_pulse = 1'b1; exit_pulse = 1'b1; cyc(1);
        enter_pulse = 1'b0; exit_pulse = 1'b0;
        chk("s3_both_at0", int'(people_count), 0);
        exit_pulse = 1'b1; cyc(1); exit_pulse = 1'b0;
        chk("s3_exit_at0", int'(people_count), 0);
        enter_pulse = 1'b1; cyc(40); enter_pulse = 1'b0;
        chk("s3_enter_ceiling", int'(people_count), 31);
        enter_pulse = 1'b1; exit_pulse = 1'b1; cyc(1);
        enter_pulse = 1'b0; exit_pulse = 1'b0;
        chk("s3_both_at31", int'(people_count), 31);
        enter_pulse = 1'b1; cyc(1); enter_pulse = 1'b0;
        chk("s3_enter_at31", int'(people_count), 31);
        $display("txn 3: people=%0d", people_count);

        // 4: reach the limit, then clear
        k = 0;
        while (m_energy < 199 && k < 2000) begin run_ticks(1); k++; end
        chk("s4_energy199", int'(energy), 199);
        chk("s4_below_limit", int'(over_limit), 0);
        k = 0;
        while (m_energy < 200 && k < 10) begin run_ticks(1); k++; end
        chk("s4_energy200", int'(energy), 200);
        chk("s4_over_limit", int'(over_limit), 1);
        pulse_clr();
        chk("s4_clr_done", int'(clr_done), 1);
        cyc(1);
        chk("s4_clr_done_end", int'(clr_done), 0);
        chk("s4_energy_clr", int'(energy), 0);
        chk("s4_limit_clr", int'(over_limit), 0);
        chk("s4_people_kept", int'(people_count), 31);
        $display("txn 4: energy=%0d over_limit=%0d", energy, over_limit);

        // 5: long snapshot hold overflows the pending counter
        k = 0;
        while (m_energy < 42 && k < 500) begin run_ticks(1); k++; end
        chk("s5_energy42", int'(energy), 42);
        rd_req = 1'b1; cyc(1); rd_req = 1'b0;
        chk("s5_rd_valid", int'(rd_valid), 1);
        chk("s5_rd_data", int'(rd_data), 42);
        cyc(9 * TICK_DIV);
        chk("s5_rd_data_held", int'(rd_data), 42);
        chk("s5_rd_valid_held", int'(rd_valid), 1);
        chk("s5_tick_lost", int'(tick_lost), 1);
        chk("s5_model_pend", m_pend, 7);
        wait_presc(1);
        rd_ack = 1'b1; cyc(1); rd_ack = 1'b0;
        chk("s5_rd_valid_drop", int'(rd_valid), 0);
        cyc(17);
        chk("s5_model_drained", m_pend, 0);
        chk("s5_lost_sticky", int'(tick_lost), 1);
        $display("txn 5: energy=%0d tick_lost=%0d", energy, tick_lost);

        // 6: clear and read together with two ticks pending
        rd_req = 1'b1; cyc(1); rd_req = 1'b0;
        k = 0;
        while (m_pend < 2 && k < 3 * TICK_DIV) begin cyc(1); k++; end
        chk("s6_model_pend2", m_pend, 2);
        wait_presc(4);
        rd_ack = 1'b1; clr_req = 1'b1; rd_req = 1'b1;
        cyc(1);
        rd_ack = 1'b0;
        cyc(1);
        chk("s6_clr_first", int'(clr_done), 1);
        clr_req = 1'b0;
        cyc(1);
        chk("s6_model_pend0", m_pend, 0);
        chk("s6_lost_cleared", int'(tick_lost), 0);
        cyc(1);
        rd_req = 1'b0;
        chk("s6_snap_valid", int'(rd_valid), 1);
        chk("s6_snap_zero", int'(rd_data), 0);
        rd_ack = 1'b1; cyc(1); rd_ack = 1'b0;
        $display("txn 6: rd_data=%0d", rd_data);

        // 7: asynchronous reset during a snapshot
        run_ticks(1);
        rd_req = 1'b1; cyc(1); rd_req = 1'b0;
        cyc(2);
        chk("s7_in_snap", int'(rd_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s7_async_rd_valid", int'(rd_valid), 0);
        chk("s7_async_people", int'(people_count), 0);
        chk("s7_async_energy", int'(energy), 0);
        chk("s7_async_rd_data", int'(rd_data), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("s7_idle_after", int'(rd_valid), 0);
        rd_req = 1'b1; cyc(1); rd_req = 1'b0;
        chk("s7_snap_valid", int'(rd_valid), 1);
        chk("s7_snap_zero", int'(rd_data), 0);
        rd_ack = 1'b1; cyc(1); rd_ack = 1'b0;
        cyc(2);
        $display("txn 7: rd_valid=%0d energy=%0d", rd_valid, energy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
